i2s_rx: RTL and testbench



---
 rtl/i2s_pkg.sv | 7 +
 rtl/i2s_rx_sync.sv | 27 ++
 rtl/i2s_rx.sv | 114 +++++++++++
 tb/tb_i2s_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S receive path.
package i2s_pkg;
  typedef enum logic {UNLOCKED, RUN} state_e;
  localparam logic WS_LEFT = 1'b0;
  localparam logic WS_RIGHT = 1'b1;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/i2s_rx_sync.sv
// i2s_rx_sync: N-bit multi-stage synchroniser plus delay register; bit 0 is the edge-detected clock.
module i2s_rx_sync
  import i2s_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         i_sys_clk,
  input  logic         i_sys_rst,
  input  logic [N-1:0] d_i,
  output logic [N-2:0] data_o,
  output logic         rise_o
);
  logic [SYNC_STAGES-1:0][N-1:0] stg_q;
  logic                          dly_q;
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      stg_q <= '0;
      dly_q <= 1'b0;
    end else begin
      stg_q <= {stg_q[SYNC_STAGES-2:0], d_i};
      dly_q <= stg_q[SYNC_STAGES-1][0];
    end
  end
  // data bits come from the same stage as the clock so they are stable at the rise
  assign data_o = stg_q[SYNC_STAGES-1][N-1:1];
  assign rise_o = stg_q[SYNC_STAGES-1][0] & ~dly_q;
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S slave receiver (one-bit WS delay, MSB first) with lock and framing-error flags.
// Define I2S_RX_NEGATE_EN to two's-complement negate each received word before output.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_sck,
  input  logic                  i_ws,
  input  logic                  i_sd,
  output logic [DATA_WIDTH-1:0] o_left_data,
  output logic [DATA_WIDTH-1:0] o_right_data,
  output logic                  o_left_vld,
  output logic                  o_right_vld,
  output logic                  o_locked,
  output logic                  o_frame_err
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  if (DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_bad_width
    $error("i2s_rx: DATA_WIDTH must be within 8..32");
  end
  logic [1:0]            sync_w;
  logic                  rise_w, ws_w, sd_w, ws_chg_w;
  logic [DATA_WIDTH-1:0] word_w;
  state_e                state_q, state_d;
  logic                  ws_prev_q, ws_prev_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  fin_q, fin_d, fin_ch_q, fin_ch_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                  left_vld_q, left_vld_d, right_vld_q, right_vld_d, frame_err_q, frame_err_d;
  i2s_rx_sync #(.N(3)) u_sync (
    .i_sys_clk(i_sys_clk),
    .i_sys_rst(i_sys_rst),
    .d_i      ({i_sd, i_ws, i_sck}),
    .data_o   (sync_w),
    .rise_o   (rise_w)
  );
  assign ws_w = sync_w[0];
  assign sd_w = sync_w[1];
  assign ws_chg_w = ws_w != ws_prev_q;
`ifdef I2S_RX_NEGATE_EN
  assign word_w = ~shreg_q + DATA_WIDTH'(1);
`else
  assign word_w = shreg_q;
`endif
  // a WS change arrives together with the LSB of the word that is ending
  always_comb begin
    state_d = state_q;
    ws_prev_d = ws_prev_q;
    cnt_d = cnt_q;
    shreg_d = shreg_q;
    fin_d = 1'b0;
    fin_ch_d = fin_ch_q;
    err_d = 1'b0;
    if (rise_w) begin
      ws_prev_d = ws_w;
      if (state_q == UNLOCKED) begin
        state_d = ws_chg_w ? RUN : UNLOCKED;
        cnt_d = '0;
      end else begin
        shreg_d = {shreg_q[DATA_WIDTH-2:0], sd_w};
        cnt_d = ws_chg_w ? '0 : (cnt_q == CW'(DATA_WIDTH)) ? cnt_q : cnt_q + CW'(1);
        fin_d = ws_chg_w && cnt_q == CW'(DATA_WIDTH - 1);
        err_d = ws_chg_w && cnt_q != CW'(DATA_WIDTH - 1);
        fin_ch_d = ws_prev_q;
      end
    end
  end
  always_comb begin
    left_vld_d = fin_q && fin_ch_q == WS_LEFT;
    right_vld_d = fin_q && fin_ch_q == WS_RIGHT;
    left_d = left_vld_d ? word_w : left_q;
    right_d = right_vld_d ? word_w : right_q;
    frame_err_d = err_q;
  end
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= UNLOCKED;
      ws_prev_q <= 1'b0;
      cnt_q <= '0;
      shreg_q <= '0;
      fin_q <= 1'b0;
      fin_ch_q <= 1'b0;
      err_q <= 1'b0;
      left_q <= '0;
      right_q <= '0;
      left_vld_q <= 1'b0;
      right_vld_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_prev_q <= ws_prev_d;
      cnt_q <= cnt_d;
      shreg_q <= shreg_d;
      fin_q <= fin_d;
      fin_ch_q <= fin_ch_d;
      err_q <= err_d;
      left_q <= left_d;
      right_q <= right_d;
      left_vld_q <= left_vld_d;
      right_vld_q <= right_vld_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign o_left_data = left_q;
  assign o_right_data = right_q;
  assign o_left_vld = left_vld_q;
  assign o_right_vld = right_vld_q;
  assign o_frame_err = frame_err_q;
  assign o_locked = state_q == RUN;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: scoreboard bench; stimulus queues expected outputs, a monitor pops them as the receiver reports.
module tb_i2s_rx;
  logic        clk, rst, sck, ws, sd;
  logic [15:0] left_data, right_data;
  logic        left_vld, right_vld, locked, frame_err;
  typedef struct {int kind; logic [15:0] data; int cyc;} ev_t;
  typedef struct {logic ch; logic [31:0] val; int len; int exp; logic [15:0] dv;} wd_t;
  ev_t sb[$];
  wd_t wq[$];
  int  pass = 0, total = 0, cyc = 0;
  i2s_rx #(.DATA_WIDTH(16)) dut (
    .i_sys_clk   (clk),
    .i_sys_rst   (rst),
    .i_sck       (sck),
    .i_ws        (ws),
    .i_sd        (sd),
    .o_left_data (left_data),
    .o_right_data(right_data),
    .o_left_vld  (left_vld),
    .o_right_vld (right_vld),
    .o_locked    (locked),
    .o_frame_err (frame_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [15:0] xv(input logic [15:0] v);
`ifdef I2S_RX_NEGATE_EN
    return ~v + 16'd1;
`else
    return v;
`endif
  endfunction
  task automatic add(input logic ch, input logic [31:0] val, input int len, input int exp, input logic [15:0] dv);
    wd_t w;
    w.ch = ch; w.val = val; w.len = len; w.exp = exp; w.dv = dv;
    wq.push_back(w);
  endtask
  task automatic send_bit(input logic w, input logic b, output int rc);
    sck = 1'b0; ws = w; sd = b;
    repeat (2) @(negedge clk);
    sck = 1'b1;
    rc = cyc;
    repeat (2) @(negedge clk);
  endtask
  // LSB of each word carries the next word's WS; the final word's LSB flips WS
  task automatic stream();
    int   rc;
    logic w;
    ev_t  e;
    for (int i = 0; i < wq.size(); i++) begin
      for (int j = wq[i].len - 1; j >= 0; j--) begin
        w = (j != 0) ? wq[i].ch : (i + 1 < wq.size()) ? wq[i+1].ch : ~wq[i].ch;
        send_bit(w, wq[i].val[j], rc);
        if (j == 0 && wq[i].exp != 0) begin
          e.kind = (wq[i].exp == 2) ? 2 : int'(wq[i].ch);
          e.data = wq[i].dv;
          e.cyc = rc + 4;
          sb.push_back(e);
        end
      end
    end
    wq.delete();
    repeat (10) @(negedge clk);
  endtask
  task automatic pop(input int kind, input logic [15:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL unexpected_output: got kind %0d data %h at cycle %0d, expected nothing", kind, d, cyc);
    end else begin
      e = sb.pop_front();
      chk("out_kind", kind, e.kind);
      if (kind != 2) chk("out_data", d, e.data);
      chk("out_cycle", cyc, e.cyc);
    end
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (left_vld && right_vld) begin
      total++;
      $display("FAIL vld_exclusive: got both vld high at cycle %0d, expected at most one", cyc);
    end
    if (left_vld) pop(0, left_data);
    if (right_vld) pop(1, right_data);
    if (frame_err) pop(2, 16'h0);
  end
  task automatic reset_pulse();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_left_data", left_data, 0);
    chk("rst_right_data", right_data, 0);
    chk("rst_left_vld", left_vld, 0);
    chk("rst_right_vld", right_vld, 0);
    chk("rst_locked", locked, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    // clean start: first left word only locks
    add(0, 32'h1234, 16, 0, 0);
    add(1, 32'hABCD, 16, 1, xv(16'hABCD));
    add(0, 32'h1234, 16, 1, xv(16'h1234));
    add(1, 32'hABCD, 16, 1, xv(16'hABCD));
    add(0, 32'h1234, 16, 1, xv(16'h1234));
    add(1, 32'hABCD, 16, 1, xv(16'hABCD));
    stream();
    chk("t1_locked", locked, 1);
    chk("t1_left_held", left_data, xv(16'h1234));
    // start mid-word at bit 7 of a left word
    reset_pulse();
    chk("t2_unlocked", locked, 0);
    add(0, 32'h00A5, 8, 0, 0);
    add(1, 32'h5A5A, 16, 1, xv(16'h5A5A));
    add(0, 32'h0F0F, 16, 1, xv(16'h0F0F));
    stream();
    chk("t2_locked", locked, 1);
    // short right word of 10 bits
    add(1, 32'h02AB, 10, 2, 0);
    stream();
    chk("t3_right_held", right_data, xv(16'h5A5A));
    chk("t3_left_held", left_data, xv(16'h0F0F));
    add(0, 32'h2468, 16, 1, xv(16'h2468));
    add(1, 32'h9999, 16, 1, xv(16'h9999));
    stream();
    // long left word of 20 bits
    add(0, 32'hABCDE, 20, 2, 0);
    stream();
    chk("t4_locked", locked, 1);
    chk("t4_left_held", left_data, xv(16'h2468));
    add(1, 32'h4321, 16, 1, xv(16'h4321));
    add(0, 32'h8765, 16, 1, xv(16'h8765));
    stream();
`ifdef I2S_RX_NEGATE_EN
    add(1, 32'h8000, 16, 1, 16'h8000);
    add(0, 32'h0001, 16, 1, 16'hFFFF);
    add(1, 32'h0000, 16, 1, 16'h0000);
    add(0, 32'h1234, 16, 1, 16'hEDCC);
    add(1, 32'h7FFF, 16, 1, 16'h8001);
`else
    add(1, 32'h8000, 16, 1, 16'h8000);
    add(0, 32'h0001, 16, 1, 16'h0001);
    add(1, 32'h0000, 16, 1, 16'h0000);
    add(0, 32'h1234, 16, 1, 16'h1234);
    add(1, 32'h7FFF, 16, 1, 16'h7FFF);
`endif
    stream();
    // reset in the middle of a left word
    add(0, 32'h1111, 16, 0, 0);
    add(1, 32'h2222, 16, 1, xv(16'h2222));
    add(0, 32'h3333, 16, 1, xv(16'h3333));
    fork
      stream();
      begin
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_left_data", left_data, 0);
        chk("t6_right_data", right_data, 0);
        chk("t6_locked", locked, 0);
        chk("t6_vld_err", {left_vld, right_vld, frame_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_unlocked_release", locked, 0);
        repeat (8) @(negedge clk);
        chk("t6_unlocked_midword", locked, 0);
      end
    join
    chk("t6_relocked", locked, 1);
    chk("t6_right_data", right_data, xv(16'h2222));
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
